// File: rtl/pcm_output_fifo.sv
// pcm_output_fifo: round/saturate FIR samples to signed PCM and buffer them in a FWFT FIFO.
// Optional PCM_FIFO_DROP_COUNT_EN adds a saturating dropped-sample counter on drop_count.
module pcm_output_fifo #(
  parameter int IN_WIDTH  = 40,
  parameter int FRAC      = 8,
  parameter int OUT_WIDTH = 24,
  parameter int DEPTH     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [IN_WIDTH-1:0]          din,
  input  logic                         din_valid,
  output logic [OUT_WIDTH-1:0]         dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         full,
  output logic                         overflow,
  output logic                         sat_flag,
  input  logic                         clr_flags,
  output logic [15:0]                  drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic signed [IN_WIDTH:0] RND  = (IN_WIDTH+1)'(2**FRAC/2);
  localparam logic signed [IN_WIDTH:0] MAXV = {{(IN_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH:0] MINV = ~MAXV;
  logic signed [IN_WIDTH:0] sum, rnd;
  logic hi, lo;
  logic [OUT_WIDTH-1:0] sat, s_data;
  logic s_valid, rd, wr, drop;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [OUT_WIDTH-1:0] mem [DEPTH];
  assign sum = $signed({din[IN_WIDTH-1], din}) + RND;
  assign rnd = sum >>> FRAC;
  assign hi  = rnd > MAXV;
  assign lo  = rnd < MINV;
  assign sat = hi ? MAXV[OUT_WIDTH-1:0] : lo ? MINV[OUT_WIDTH-1:0] : rnd[OUT_WIDTH-1:0];
  assign dout_valid = level != '0;
  assign full       = level == (AW+1)'(DEPTH);
  assign dout       = dout_valid ? mem[rd_ptr] : '0;
  assign rd   = dout_valid & dout_ready;
  assign wr   = s_valid & (~full | rd);
  assign drop = s_valid & full & ~rd;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_valid  <= 1'b0;
      s_data   <= '0;
      sat_flag <= 1'b0;
    end else begin
      s_valid  <= din_valid;
      if (din_valid) s_data <= sat;
      sat_flag <= (din_valid & (hi | lo)) | (sat_flag & ~clr_flags);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      level    <= level + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
      overflow <= drop | (overflow & ~clr_flags);
    end
  end
  // Storage is left unreset so it can map onto plain RAM; level gates visibility.
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= s_data;
`ifdef PCM_FIFO_DROP_COUNT_EN
  logic [15:0] dcnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dcnt <= '0;
    else if (drop) dcnt <= dcnt + {15'd0, dcnt != 16'hFFFF};
    else if (clr_flags) dcnt <= '0;
  end
  assign drop_count = dcnt;
`else
  assign drop_count = 16'h0000;
`endif
endmodule

// File: tb/tb_pcm_output_fifo.sv
// tb_pcm_output_fifo: directed stimulus with a queue scoreboard and an independent output monitor.
module tb_pcm_output_fifo;
  logic clk = 0, reset = 0, din_valid = 0, dout_ready = 0, clr_flags = 0;
  logic [39:0] din = '0;
  logic [23:0] dout;
  logic dout_valid, full, overflow, sat_flag;
  logic [4:0] level;
  logic [15:0] drop_count;
  int checks = 0, failures = 0;
  logic [23:0] q[$];
`ifdef PCM_FIFO_DROP_COUNT_EN
  localparam int DC_EN = 1;
`else
  localparam int DC_EN = 0;
`endif

  pcm_output_fifo dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .level(level), .full(full), .overflow(overflow), .sat_flag(sat_flag),
    .clr_flags(clr_flags), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (reset && dout_valid && dout_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dout_unexpected actual=%0h required=none", dout);
      end else chk("dout", dout, q.pop_front());
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [39:0] d, input logic [23:0] e);
    din = d;
    din_valid = 1;
    q.push_back(e);
    tick;
    din_valid = 0;
  endtask

  task automatic stream(input int base, input int n, input int nkeep);
    for (int i = 0; i < n; i++) begin
      din = 40'(base + i) << 8;
      din_valid = 1;
      if (i < nkeep) q.push_back(24'(base + i));
      tick;
    end
    din_valid = 0;
  endtask

  task automatic wait_drain;
    tick;
    tick;
    for (int i = 0; i < 200 && level != 0; i++) tick;
    chk("drain_level", level, 0);
    chk("drain_queue", q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick;
    tick;
    chk("rst_valid", dout_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_dout", dout, 0);
    chk("rst_flags", {full, overflow, sat_flag}, 0);
    chk("rst_drop", drop_count, 0);
    reset = 1;
    tick;
    dout_ready = 1;
    send(40'h180, 24'd2);
    chk("lat1_valid", dout_valid, 0);
    tick;
    chk("lat2_valid", dout_valid, 1);
    chk("lat2_dout", dout, 24'd2);
    tick;
    send(-40'sh180, 24'hFFFFFF);
    send(40'h17F, 24'd1);
    wait_drain;
    send(40'h80000000, 24'h7FFFFF);
    chk("sat_set", sat_flag, 1);
    send(40'hFF00000000, 24'h800000);
    wait_drain;
    clr_flags = 1;
    tick;
    clr_flags = 0;
    chk("sat_clr", sat_flag, 0);
    clr_flags = 1;
    send(40'h80000000, 24'h7FFFFF);
    clr_flags = 0;
    chk("sat_clr_event", sat_flag, 1);
    wait_drain;
    dout_ready = 0;
    stream(1, 17, 16);
    tick;
    tick;
    chk("fill_level", level, 16);
    chk("fill_full", full, 1);
    chk("fill_overflow", overflow, 1);
    chk("fill_drop", drop_count, 32'(DC_EN));
    dout_ready = 1;
    wait_drain;
    chk("drain_full", full, 0);
    clr_flags = 1;
    tick;
    clr_flags = 0;
    chk("clr_overflow", overflow, 0);
    chk("clr_drop", drop_count, 0);
    chk("clr_sat", sat_flag, 0);
    dout_ready = 0;
    stream(100, 16, 16);
    tick;
    tick;
    chk("rw_prefill", level, 16);
    for (int i = 0; i < 20; i++) begin
      din = 40'(116 + i) << 8;
      din_valid = 1;
      q.push_back(24'(116 + i));
      tick;
      dout_ready = 1;
      if (i > 0) chk("rw_level", level, 16);
    end
    din_valid = 0;
    tick;
    chk("rw_last_level", level, 16);
    chk("rw_overflow", overflow, 0);
    wait_drain;
    dout_ready = 0;
    stream(200, 36, 16);
    tick;
    tick;
    chk("drop_level", level, 16);
    chk("drop_overflow", overflow, 1);
    chk("drop_count", drop_count, 32'(DC_EN * 20));
    dout_ready = 1;
    for (int i = 0; i < 40 && level != 5; i++) tick;
    dout_ready = 0;
    chk("pre_rst_level", level, 5);
    #2 reset = 0;
    #1;
    chk("arst_valid", dout_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_dout", dout, 0);
    chk("arst_flags", {full, overflow, sat_flag}, 0);
    chk("arst_drop", drop_count, 0);
    q.delete();
    tick;
    reset = 1;
    tick;
    dout_ready = 1;
    send(40'h300, 24'd3);
    wait_drain;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
